tx_arbiter: RTL and testbench
=============================

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesting router-core ports (2..8).
REQ-002 The block SHALL have parameter DATA_W, default 8, giving the TX data width in bits.
REQ-003 The block SHALL have one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  system clock; all state changes on its rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req  input  NUM_REQ  per-port request; port i holds req[i] high with stable data until granted.
REQ-007 req_data  input  NUM_REQ*DATA_W  port i data in bits [i*DATA_W +: DATA_W].
REQ-008 gnt  output  NUM_REQ  one-hot single-cycle pulse; port i's data was captured this cycle.
REQ-009 TX_Data  output  DATA_W  registered data to the TX unit.
REQ-010 TX_Data_Valid  output  1  data valid to the TX unit.
REQ-011 TX_Data_Ready  input  1  TX unit idle/ready; falls when the TX unit takes the data, rises again when transmission ends.
REQ-012 busy  output  1  high in any state other than READY.
REQ-013 tx_err  output  1  single-cycle timeout pulse (see Configuration).

Function
REQ-014 The FSM SHALL have states IDLE, READY, SEND; any other encoding SHALL go to IDLE next cycle.
REQ-015 In IDLE, next state SHALL be READY when TX_Data_Ready=1, else IDLE.
REQ-016 In READY with req!=0, the block SHALL, in the same cycle, pick the winner round-robin starting at pointer ptr; pulse gnt[winner]; register req_data of the winner into TX_Data; and go to SEND.
REQ-017 In READY with req==0, the FSM SHALL stay in READY; gnt=0.
REQ-018 ptr SHALL update to (winner+1) mod NUM_REQ on each grant; it SHALL not change otherwise.
REQ-019 In SEND, TX_Data_Valid SHALL be 1 and TX_Data SHALL hold; the FSM SHALL go to IDLE when TX_Data_Ready=0.
REQ-020 TX_Data_Valid SHALL be 0 in IDLE and READY; gnt SHALL be 0 outside READY.
REQ-021 Grant-to-TX_Data_Valid latency SHALL be 1 cycle; at most one grant per TX transaction.
REQ-022 A requester deasserting req before its grant SHALL be skipped without penalty; a requester winning while holding req SHALL only win again after all other active requesters have been served.
REQ-023 TX_Data_Ready dropping while in READY SHALL send the FSM to IDLE with no grant.

Reset
REQ-024 With rst=1 at a clock edge: state=IDLE, ptr=0, TX_Data=0, TX_Data_Valid=0, gnt=0, tx_err=0, timeout counter=0, regardless of the current state (including mid-SEND).
REQ-025 busy SHALL be 1 during and immediately after reset until READY is reached.

Configuration
REQ-026 Macro TX_ARB_TIMEOUT_EN defined: an 8-bit counter SHALL count SEND cycles; when it reaches 255 with TX_Data_Ready still 1, the block SHALL pulse tx_err for one cycle, drop TX_Data_Valid, and return to IDLE; the counter SHALL clear on leaving SEND.
REQ-027 Macro TX_ARB_TIMEOUT_EN undefined: no counter SHALL be built; tx_err SHALL be tied 0; SEND SHALL wait indefinitely.

Structure
REQ-028 Package tx_arb_pkg SHALL hold the state encodings (IDLE=2'd0, READY=2'd1, SEND=2'd2), the default parameter values, and the timeout limit constant 8'd255.
REQ-029 The round-robin pick SHALL be a sub-module rr_pick: inputs req and ptr; outputs the winner index and the any-request flag; purely combinational.

Verification
REQ-030 Reset then TX_Data_Ready=1, req=4'b0001, data0=8'hA5: gnt=4'b0001 one cycle after reaching READY; next cycle TX_Data=8'hA5 and TX_Data_Valid=1.
REQ-031 req=4'b1111 held, with the TX unit modelled as ready-drop after 2 cycles and ready-rise after 5: grants SHALL occur in order 0,1,2,3,0.
REQ-032 ptr=2 and req=4'b0011: grant goes to port 0, then ptr=1.
REQ-033 rst=1 asserted mid-SEND: next cycle TX_Data_Valid=0, state=IDLE, ptr=0.
REQ-034 TX_ARB_TIMEOUT_EN defined, TX_Data_Ready held 1 in SEND: tx_err pulses after 255 SEND cycles, TX_Data_Valid falls, FSM returns to IDLE; with the macro undefined, tx_err stays 0.
REQ-035 TX_Data_Ready falls in READY while req=0: FSM goes to IDLE, no gnt.

Source files
------------

// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared constants for the TX arbiter.
// Holds the FSM state encoding, the default parameter values and the
// SEND timeout limit used when TX_ARB_TIMEOUT_EN is defined.
package tx_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        SEND  = 2'd2
    } state_e;

    localparam int NUM_REQ_DEF = 4;
    localparam int DATA_W_DEF  = 8;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'd255;

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
// Returns the first requesting port at or above ptr_i, wrapping to the
// lowest requesting port when nothing at or above ptr_i is requesting.
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [IDX_W-1:0]   winner_o,
    output logic               any_o
);

    logic             found_hi;
    logic [IDX_W-1:0] hi_idx;
    logic [IDX_W-1:0] lo_idx;

    // Scan downwards so the last hit is the lowest index in each region
    always_comb begin
        found_hi = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            if (req_i[j]) begin
                lo_idx = IDX_W'(j);
                if (j >= int'(ptr_i)) begin
                    hi_idx   = IDX_W'(j);
                    found_hi = 1'b1;
                end
            end
        end
        any_o    = |req_i;
        winner_o = found_hi ? hi_idx : lo_idx;
    end

endmodule

// File: rtl/tx_arbiter.sv
// tx_arbiter: round-robin arbiter feeding a single TX unit.
// Requests are granted only in READY; the winner's data is registered into
// TX_Data and presented with TX_Data_Valid until the TX unit drops ready.
// Optional macro TX_ARB_TIMEOUT_EN adds an 8-bit SEND watchdog that pulses
// tx_err and abandons the transfer after 255 SEND cycles.
module tx_arbiter
    import tx_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic [DATA_W-1:0]         TX_Data,
    output logic                      TX_Data_Valid,
    input  logic                      TX_Data_Ready,
    output logic                      busy,
    output logic                      tx_err
);

    localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    state_e             state_q;
    logic [IDX_W-1:0]   ptr_q;
    logic [IDX_W-1:0]   ptr_d;
    logic [DATA_W-1:0]  tx_data_q;
    logic               tx_valid_q;
    logic [IDX_W-1:0]   winner;
    logic               any_req;
    logic               grant_en;
    logic [DATA_W-1:0]  win_data;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .winner_o (winner),
        .any_o    (any_req)
    );

    // Grant decode, winner data mux and next pointer; a grant needs the TX unit still ready
    always_comb begin
        grant_en = (state_q == READY) && TX_Data_Ready && any_req && !rst;
        gnt      = '0;
        win_data = '0;
        for (int j = 0; j < NUM_REQ; j++) begin
            if (winner == IDX_W'(j)) begin
                gnt[j]   = grant_en;
                win_data = req_data[j*DATA_W +: DATA_W];
            end
        end
        ptr_d = ptr_q;
        if (grant_en) begin
            ptr_d = (int'(winner) == NUM_REQ - 1) ? '0 : winner + IDX_W'(1);
        end
    end

`ifdef TX_ARB_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic [7:0] cnt_d;
    logic       tx_err_q;

    // Count of SEND cycles including the current one
    always_comb begin
        cnt_d = cnt_q + 8'd1;
    end
`endif

    // Main FSM with registered TX outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            tx_data_q  <= '0;
            tx_valid_q <= 1'b0;
`ifdef TX_ARB_TIMEOUT_EN
            cnt_q      <= '0;
            tx_err_q   <= 1'b0;
`endif
        end else begin
            ptr_q <= ptr_d;
`ifdef TX_ARB_TIMEOUT_EN
            tx_err_q <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    tx_valid_q <= 1'b0;
                    if (TX_Data_Ready) begin
                        state_q <= READY;
                    end
                end
                READY: begin
                    if (!TX_Data_Ready) begin
                        state_q <= IDLE;
                    end else if (grant_en) begin
                        tx_data_q  <= win_data;
                        tx_valid_q <= 1'b1;
                        state_q    <= SEND;
                    end
                end
                SEND: begin
                    if (!TX_Data_Ready) begin
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
`ifdef TX_ARB_TIMEOUT_EN
                        cnt_q      <= '0;
                    end else if (cnt_d == TIMEOUT_LIMIT) begin
                        tx_err_q   <= 1'b1;
                        tx_valid_q <= 1'b0;
                        state_q    <= IDLE;
                        cnt_q      <= '0;
                    end else begin
                        cnt_q      <= cnt_d;
`endif
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    state_q    <= IDLE;
                end
            endcase
        end
    end

    assign TX_Data       = tx_data_q;
    assign TX_Data_Valid = tx_valid_q;
    assign busy          = (state_q != READY);

`ifdef TX_ARB_TIMEOUT_EN
    assign tx_err = tx_err_q;
`else
    assign tx_err = 1'b0;
`endif

endmodule

// File: tb/tb_tx_arbiter.sv
// tb_tx_arbiter: directed self-checking bench for tx_arbiter (NUM_REQ=4, DATA_W=8).
module tb_tx_arbiter;
    import tx_arb_pkg::*;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  TX_Data;
    logic        TX_Data_Valid;
    logic        TX_Data_Ready;
    logic        busy;
    logic        tx_err;

    int checks;
    int failures;

    tx_arbiter #(.NUM_REQ(4), .DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .req_data      (req_data),
        .gnt           (gnt),
        .TX_Data       (TX_Data),
        .TX_Data_Valid (TX_Data_Valid),
        .TX_Data_Ready (TX_Data_Ready),
        .busy          (busy),
        .tx_err        (tx_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = 4'b0000;
        TX_Data_Ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Drives a granted transfer to completion and returns to READY
    task automatic finish_txn();
        tick();
        req = 4'b0000;
        TX_Data_Ready = 1'b0;
        tick();
        TX_Data_Ready = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL reset_state got=%0d exp=0", dut.state_q); end
        checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL reset_ptr got=%0d exp=0", dut.ptr_q); end
        checks++; if (TX_Data !== 8'h00) begin failures++; $display("FAIL reset_data got=%h exp=00", TX_Data); end
        checks++; if (TX_Data_Valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", TX_Data_Valid); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
        checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL reset_txerr got=%b exp=0", tx_err); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL reset_busy got=%b exp=1", busy); end
    endtask

    task automatic test_single();
        do_reset();
        req_data = 32'h0000_00A5;
        req = 4'b0001;
        TX_Data_Ready = 1'b1;
        tick();
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_busy_ready got=%b exp=0", busy); end
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL single_gnt got=%b exp=0001", gnt); end
        checks++; if (TX_Data_Valid !== 1'b0) begin failures++; $display("FAIL single_valid_early got=%b exp=0", TX_Data_Valid); end
        tick();
        checks++; if (TX_Data !== 8'hA5) begin failures++; $display("FAIL single_data got=%h exp=a5", TX_Data); end
        checks++; if (TX_Data_Valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%b exp=1", TX_Data_Valid); end
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL single_gnt_send got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_send got=%b exp=1", busy); end
        tick();
        checks++; if (TX_Data !== 8'hA5 || TX_Data_Valid !== 1'b1) begin failures++; $display("FAIL single_hold got=%h/%b exp=a5/1", TX_Data, TX_Data_Valid); end
        req = 4'b0000;
        TX_Data_Ready = 1'b0;
        tick();
        checks++; if (TX_Data_Valid !== 1'b0 || dut.state_q !== IDLE) begin failures++; $display("FAIL single_end got valid=%b state=%0d exp=0/0", TX_Data_Valid, dut.state_q); end
        checks++; if (dut.ptr_q !== 2'd1) begin failures++; $display("FAIL single_ptr got=%0d exp=1", dut.ptr_q); end
    endtask

    task automatic test_round_robin();
        logic [7:0] dvals [4];
        int         exp_order [5];
        logic [3:0] exp_gnt;
        dvals = '{8'h11, 8'h22, 8'h33, 8'h44};
        exp_order = '{0, 1, 2, 3, 0};
        do_reset();
        req_data = {dvals[3], dvals[2], dvals[1], dvals[0]};
        req = 4'b1111;
        TX_Data_Ready = 1'b1;
        for (int g = 0; g < 5; g++) begin
            for (int c = 0; c < 20; c++) begin
                if (gnt != 4'b0000) break;
                tick();
            end
            exp_gnt = 4'b0001 << exp_order[g];
            checks++; if (gnt !== exp_gnt) begin failures++; $display("FAIL rr_gnt_%0d got=%b exp=%b", g, gnt, exp_gnt); end
            tick();
            checks++; if (TX_Data !== dvals[exp_order[g]]) begin failures++; $display("FAIL rr_data_%0d got=%h exp=%h", g, TX_Data, dvals[exp_order[g]]); end
            tick();
            TX_Data_Ready = 1'b0;
            for (int c = 0; c < 5; c++) tick();
            TX_Data_Ready = 1'b1;
        end
    endtask

    task automatic test_ptr_wrap();
        do_reset();
        req_data = 32'h4433_2211;
        req = 4'b0010;
        TX_Data_Ready = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL wrap_setup_gnt got=%b exp=0010", gnt); end
        finish_txn();
        checks++; if (dut.ptr_q !== 2'd2) begin failures++; $display("FAIL wrap_ptr_before got=%0d exp=2", dut.ptr_q); end
        req = 4'b0011;
        #1;
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL wrap_gnt got=%b exp=0001", gnt); end
        tick();
        checks++; if (dut.ptr_q !== 2'd1) begin failures++; $display("FAIL wrap_ptr_after got=%0d exp=1", dut.ptr_q); end
        checks++; if (TX_Data !== 8'h11) begin failures++; $display("FAIL wrap_data got=%h exp=11", TX_Data); end
    endtask

    task automatic test_skip();
        do_reset();
        req_data = 32'h4433_2211;
        req = 4'b0110;
        TX_Data_Ready = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL skip_first got=%b exp=0010", gnt); end
        tick();
        req = 4'b0011;
        TX_Data_Ready = 1'b0;
        tick();
        TX_Data_Ready = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0001) begin failures++; $display("FAIL skip_second got=%b exp=0001", gnt); end
        tick();
        TX_Data_Ready = 1'b0;
        tick();
        TX_Data_Ready = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL skip_third got=%b exp=0010", gnt); end
        req = 4'b0000;
    endtask

    task automatic test_reset_mid_send();
        do_reset();
        req_data = 32'h005A_0000;
        req = 4'b0100;
        TX_Data_Ready = 1'b1;
        tick();
        tick();
        checks++; if (TX_Data_Valid !== 1'b1 || dut.ptr_q !== 2'd3) begin failures++; $display("FAIL midsend_setup got valid=%b ptr=%0d exp=1/3", TX_Data_Valid, dut.ptr_q); end
        rst = 1'b1;
        tick();
        checks++; if (TX_Data_Valid !== 1'b0) begin failures++; $display("FAIL midsend_valid got=%b exp=0", TX_Data_Valid); end
        checks++; if (dut.state_q !== IDLE) begin failures++; $display("FAIL midsend_state got=%0d exp=0", dut.state_q); end
        checks++; if (dut.ptr_q !== 2'd0) begin failures++; $display("FAIL midsend_ptr got=%0d exp=0", dut.ptr_q); end
        checks++; if (TX_Data !== 8'h00 || busy !== 1'b1 || gnt !== 4'b0000) begin failures++; $display("FAIL midsend_outs got data=%h busy=%b gnt=%b exp=00/1/0000", TX_Data, busy, gnt); end
        rst = 1'b0;
        req = 4'b0000;
    endtask

    task automatic test_ready_drop();
        do_reset();
        TX_Data_Ready = 1'b1;
        tick();
        tick();
        checks++; if (dut.state_q !== READY || gnt !== 4'b0000) begin failures++; $display("FAIL drop_idle_ready got state=%0d gnt=%b exp=1/0000", dut.state_q, gnt); end
        TX_Data_Ready = 1'b0;
        tick();
        checks++; if (dut.state_q !== IDLE || TX_Data_Valid !== 1'b0) begin failures++; $display("FAIL drop_noreq got state=%0d valid=%b exp=0/0", dut.state_q, TX_Data_Valid); end
        TX_Data_Ready = 1'b1;
        tick();
        req = 4'b0001;
        TX_Data_Ready = 1'b0;
        #1;
        checks++; if (gnt !== 4'b0000) begin failures++; $display("FAIL drop_req_gnt got=%b exp=0000", gnt); end
        tick();
        checks++; if (dut.state_q !== IDLE || TX_Data_Valid !== 1'b0 || dut.ptr_q !== 2'd0) begin failures++; $display("FAIL drop_req_end got state=%0d valid=%b ptr=%0d exp=0/0/0", dut.state_q, TX_Data_Valid, dut.ptr_q); end
        req = 4'b0000;
    endtask

    task automatic test_timeout();
        int err_seen;
        err_seen = 0;
        do_reset();
        req_data = 32'h0000_0077;
        req = 4'b0001;
        TX_Data_Ready = 1'b1;
        tick();
        tick();
        req = 4'b0000;
`ifdef TX_ARB_TIMEOUT_EN
        for (int c = 0; c < 254; c++) begin
            tick();
            if (tx_err !== 1'b0) err_seen++;
        end
        checks++; if (err_seen != 0 || TX_Data_Valid !== 1'b1) begin failures++; $display("FAIL timeout_early got err_cycles=%0d valid=%b exp=0/1", err_seen, TX_Data_Valid); end
        tick();
        checks++; if (tx_err !== 1'b1) begin failures++; $display("FAIL timeout_err got=%b exp=1", tx_err); end
        checks++; if (TX_Data_Valid !== 1'b0 || dut.state_q !== IDLE) begin failures++; $display("FAIL timeout_exit got valid=%b state=%0d exp=0/0", TX_Data_Valid, dut.state_q); end
        tick();
        checks++; if (tx_err !== 1'b0) begin failures++; $display("FAIL timeout_pulse got=%b exp=0", tx_err); end
`else
        for (int c = 0; c < 300; c++) begin
            tick();
            if (tx_err !== 1'b0) err_seen++;
        end
        checks++; if (err_seen != 0) begin failures++; $display("FAIL noto_err got err_cycles=%0d exp=0", err_seen); end
        checks++; if (TX_Data_Valid !== 1'b1 || dut.state_q !== SEND) begin failures++; $display("FAIL noto_hold got valid=%b state=%0d exp=1/2", TX_Data_Valid, dut.state_q); end
`endif
        TX_Data_Ready = 1'b0;
        tick();
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        req = 4'b0000;
        req_data = 32'h0;
        TX_Data_Ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_ptr_wrap();
        test_skip();
        test_reset_mid_send();
        test_ready_drop();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
